mpu_burst_reader: RTL and testbench
===================================

# mpu_burst_reader

Transaction sequencer that sits directly upstream of the byte-level SPI master (`spi_master_11`) and turns it into an MPU-6000/9250-class sensor reader. After reset it wakes the device with one register write. Each trigger then performs one chip-selected burst read of accel, temperature and gyro registers 0x3B..0x48. It reassembles the bytes into seven signed 16-bit words and presents them with a one-cycle valid strobe to the attitude/filter logic downstream.

## Interface
Parameters:
- `BURST_ADDR`, 8'h3B: first register of the burst read.
- `BURST_LEN`, 14: bytes per burst; must be even and ≤ 14.
- `WAKE_ADDR`, 8'h6B: PWR_MGMT_1 address written once after reset.
- `WAKE_DATA`, 8'h00: value written to `WAKE_ADDR`.
- `CS_GAP`, 8: clk cycles of `cs_n` low before the first byte, and of `cs_n` high after the last byte.

Ports:
- `clk` in 1: system clock, the same clock as the SPI master.
- `rst` in 1: asynchronous, active-high reset.
- `trigger` in 1: single-cycle request for one burst.
- `spi_busy` in 1: from master `busy`.
- `spi_new_data` in 1: from master `new_data`, one-cycle pulse.
- `spi_data_out` in 8: from master `data_out`.
- `spi_start` out 1: to master `start`.
- `spi_data_in` out 8: to master `data_in`.
- `cs_n` out 1: MPU chip select, active low.
- `ready` out 1: wake write has completed.
- `sample` out 7×16 (112): {ax, ay, az, temp, gx, gy, gz}; ax occupies the MSBs, two's complement.
- `sample_valid` out 1: one-cycle strobe, `sample` updated.
- `overrun` out 1: one-cycle pulse when a trigger is dropped.

## Operation
- Reset values: `cs_n`=1, `spi_start`=0, `spi_data_in`=0, `ready`=0, `sample`=0, `sample_valid`=0, `overrun`=0. The FSM goes to WAKE_SETUP.
- States:
  - WAKE_SETUP / BURST_SETUP: `cs_n`=0, count `CS_GAP`.
  - ISSUE: wait for `spi_busy`=0, then pulse `spi_start` with the current byte on `spi_data_in`.
  - WAIT: wait for `spi_new_data`.
  - HOLD: after the last byte, keep `cs_n`=0 for one cycle, then set `cs_n`=1 and count `CS_GAP`.
  - IDLE.
- Wake sequence: bytes are `WAKE_ADDR & 8'h7F`, then `WAKE_DATA`. At the end of HOLD, `ready` goes to 1 and stays there until reset.
- Burst sequence: the first byte is `BURST_ADDR | 8'h80` (read flag), and its returned byte is discarded. Then `BURST_LEN` dummy bytes 8'h00 are sent. Returned byte k (0-based) goes to word k/2; an even k is the high byte (big-endian).
- `sample` and `sample_valid` update together at HOLD exit, never mid-burst. Bytes are assembled in a shadow register. Words beyond `BURST_LEN`/2 read as 0.
- Triggers are accepted only when `ready`=1. Any earlier trigger is ignored without `overrun`.
- A trigger arriving while a burst is in progress sets a one-deep pending flag. The pending burst starts in the cycle after IDLE is reached. A trigger that arrives while pending is already set is dropped and pulses `overrun`.
- A trigger and IDLE in the same cycle start the burst immediately, with no pending flag.
- `rst` mid-transfer: all outputs return to their reset values immediately, including `cs_n`=1. The wake write then re-runs.

## Timing
- `spi_start` is high for exactly one cycle per byte. It is never asserted while `spi_busy`=1 or in the same cycle as `spi_new_data`.
- `spi_data_in` is stable from the `spi_start` cycle until the matching `spi_new_data`.
- Returned data is captured on the `spi_new_data` cycle. The next ISSUE comes no earlier than the following cycle.
- Burst latency from trigger to `sample_valid` = 1 + `CS_GAP` + 15·(byte time + 2) + 1 + `CS_GAP` cycles. Byte time is set by the SPI master.
- `cs_n` never toggles between bytes of one transaction.

## Structure
- Shared package `mpu_pkg` holds:
  - MPU register address constants (0x3B, 0x6B, and the read flag 0x80).
  - The FSM state enum.
  - Sample word index constants.
- One sub-module, `mpu_trigger_queue`, holds the pending flag and the overrun logic.
- The SPI master is instantiated by the parent, not inside this block.

## Test plan
- Reset release with an SPI slave model attached → `cs_n` low, MOSI carries 0x6B then 0x00, `cs_n` high, then `ready`=1. No `sample_valid` is produced.
- Trigger after ready, slave returning bytes 0x01..0x0E → MOSI first byte is 0xBB. `sample` = {0x0102, 0x0304, 0x0506, 0x0708, 0x090A, 0x0B0C, 0x0D0E}, and `sample_valid` pulses exactly once.
- Slave returns 0xFF,0x38 for ax → ax = −200. The other words are unchanged from the slave data.
- Trigger mid-burst, then another trigger → the second burst starts right after the first completes. The third trigger gives `overrun`=1 for one cycle. Two `sample_valid` pulses in total.
- Trigger while `ready`=0 → no burst and no `overrun`.
- `rst` asserted during byte 5 of a burst → `cs_n`=1 and `sample` is 0 in the same cycle. The wake write repeats after release, and `sample_valid` does not fire for the aborted burst.

Source files
------------

// File: rtl/mpu_pkg.sv
// Shared definitions for the MPU-6000/9250 burst reader: register map,
// sequencer states and the layout of the assembled sample vector.
package mpu_pkg;

   localparam logic [7:0] MPU_REG_ACCEL_XOUT_H = 8'h3B;
   localparam logic [7:0] MPU_REG_PWR_MGMT_1   = 8'h6B;
   localparam logic [7:0] MPU_READ_FLAG        = 8'h80;

   typedef enum logic [2:0] {
      ST_WAKE_SETUP  = 3'd0,
      ST_BURST_SETUP = 3'd1,
      ST_ISSUE       = 3'd2,
      ST_WAIT        = 3'd3,
      ST_HOLD        = 3'd4,
      ST_GAP         = 3'd5,
      ST_IDLE        = 3'd6
   } mpu_state_e;

   // Word order inside sample: W_AX sits in the MSBs.
   typedef enum int {
      W_AX   = 0,
      W_AY   = 1,
      W_AZ   = 2,
      W_TEMP = 3,
      W_GX   = 4,
      W_GY   = 5,
      W_GZ   = 6
   } sample_word_e;

   localparam int SAMPLE_WORDS  = int'(W_GZ) + 1;
   localparam int SAMPLE_W      = SAMPLE_WORDS * 16;
   localparam int MAX_BURST_LEN = SAMPLE_WORDS * 2;

   function automatic logic [7:0] mpu_read_cmd(input logic [7:0] addr);
      return addr | MPU_READ_FLAG;
   endfunction

   function automatic logic [7:0] mpu_write_cmd(input logic [7:0] addr);
      return addr & ~MPU_READ_FLAG;
   endfunction

endpackage

// File: rtl/mpu_trigger_queue.sv
// One-deep trigger queue: holds a burst request that arrives while a burst is
// running and flags triggers that find the queue already occupied.
module mpu_trigger_queue
   import mpu_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic trigger,
   input  logic ready,
   input  logic idle,
   output logic burst_go,
   output logic overrun
);

   logic pending_q;
   logic pending_d;
   logic overrun_q;
   logic overrun_d;
   logic accept;

   assign accept  = trigger & ready;
   assign overrun = overrun_q;

   // Pending/overrun bookkeeping; a queued request wins over a fresh one in IDLE.
   always_comb begin
      pending_d = pending_q;
      overrun_d = 1'b0;
      burst_go  = 1'b0;
      if (idle) begin
         burst_go  = accept | pending_q;
         pending_d = pending_q & accept;
      end else if (accept) begin
         if (pending_q) begin
            overrun_d = 1'b1;
         end else begin
            pending_d = 1'b1;
         end
      end else begin
         pending_d = pending_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         pending_q <= pending_d;
         overrun_q <= overrun_d;
      end
   end

endmodule

// File: rtl/mpu_burst_reader.sv
// Sequencer in front of a byte-level SPI master: wakes the MPU once after
// reset, then performs chip-selected burst reads and publishes 7 signed words.
module mpu_burst_reader
   import mpu_pkg::*;
#(
   parameter logic [7:0] BURST_ADDR = MPU_REG_ACCEL_XOUT_H,
   parameter int         BURST_LEN  = 14,
   parameter logic [7:0] WAKE_ADDR  = MPU_REG_PWR_MGMT_1,
   parameter logic [7:0] WAKE_DATA  = 8'h00,
   parameter int         CS_GAP     = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                trigger,
   input  logic                spi_busy,
   input  logic                spi_new_data,
   input  logic [7:0]          spi_data_out,
   output logic                spi_start,
   output logic [7:0]          spi_data_in,
   output logic                cs_n,
   output logic                ready,
   output logic [SAMPLE_W-1:0] sample,
   output logic                sample_valid,
   output logic                overrun
);

   localparam logic [7:0] GAP_LAST        = 8'(CS_GAP - 1);
   localparam logic [3:0] WAKE_LAST_IDX   = 4'd1;
   localparam logic [3:0] BURST_LAST_IDX  = 4'(BURST_LEN);
   localparam int         ALIGN_BITS      = (MAX_BURST_LEN - BURST_LEN) * 8;

   mpu_state_e          state_q, state_d;
   logic [7:0]          gap_cnt_q, gap_cnt_d;
   logic [3:0]          byte_idx_q, byte_idx_d;
   logic                is_burst_q, is_burst_d;
   logic [SAMPLE_W-1:0] shadow_q, shadow_d;
   logic [SAMPLE_W-1:0] sample_q, sample_d;
   logic                sample_valid_q, sample_valid_d;
   logic                cs_n_q, cs_n_d;
   logic                spi_start_q, spi_start_d;
   logic [7:0]          spi_data_in_q, spi_data_in_d;
   logic                ready_q, ready_d;

   logic                gap_done;
   logic                issue_ok;
   logic                last_byte;
   logic                idle;
   logic                burst_go;
   logic [7:0]          tx_byte;

   assign gap_done  = (gap_cnt_q == GAP_LAST);
   assign issue_ok  = ~spi_busy & ~spi_new_data;
   assign last_byte = (byte_idx_q == (is_burst_q ? BURST_LAST_IDX : WAKE_LAST_IDX));
   assign idle      = (state_q == ST_IDLE);
   assign tx_byte   = is_burst_q
                      ? ((byte_idx_q == 4'd0) ? mpu_read_cmd(BURST_ADDR) : 8'h00)
                      : ((byte_idx_q == 4'd0) ? mpu_write_cmd(WAKE_ADDR) : WAKE_DATA);

   assign spi_start    = spi_start_q;
   assign spi_data_in  = spi_data_in_q;
   assign cs_n         = cs_n_q;
   assign ready        = ready_q;
   assign sample       = sample_q;
   assign sample_valid = sample_valid_q;

   mpu_trigger_queue u_trigger_queue (
      .clk      (clk),
      .rst      (rst),
      .trigger  (trigger),
      .ready    (ready_q),
      .idle     (idle),
      .burst_go (burst_go),
      .overrun  (overrun)
   );

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_WAKE_SETUP;
         gap_cnt_q      <= 8'd0;
         byte_idx_q     <= 4'd0;
         is_burst_q     <= 1'b0;
         shadow_q       <= '0;
         sample_q       <= '0;
         sample_valid_q <= 1'b0;
         cs_n_q         <= 1'b1;
         spi_start_q    <= 1'b0;
         spi_data_in_q  <= 8'h00;
         ready_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         gap_cnt_q      <= gap_cnt_d;
         byte_idx_q     <= byte_idx_d;
         is_burst_q     <= is_burst_d;
         shadow_q       <= shadow_d;
         sample_q       <= sample_d;
         sample_valid_q <= sample_valid_d;
         cs_n_q         <= cs_n_d;
         spi_start_q    <= spi_start_d;
         spi_data_in_q  <= spi_data_in_d;
         ready_q        <= ready_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_WAKE_SETUP, ST_BURST_SETUP: begin
            if (gap_done) state_d = ST_ISSUE;
            else          state_d = state_q;
         end
         ST_ISSUE: begin
            if (issue_ok) state_d = ST_WAIT;
            else          state_d = ST_ISSUE;
         end
         ST_WAIT: begin
            if (spi_new_data) state_d = last_byte ? ST_HOLD : ST_ISSUE;
            else              state_d = ST_WAIT;
         end
         ST_HOLD: state_d = ST_GAP;
         ST_GAP: begin
            if (gap_done) state_d = ST_IDLE;
            else          state_d = ST_GAP;
         end
         ST_IDLE: begin
            if (burst_go) state_d = ST_BURST_SETUP;
            else          state_d = ST_IDLE;
         end
         default: state_d = ST_WAKE_SETUP;
      endcase
   end

   // Output and datapath updates; outputs are registered from these values.
   always_comb begin
      gap_cnt_d      = gap_cnt_q;
      byte_idx_d     = byte_idx_q;
      is_burst_d     = is_burst_q;
      shadow_d       = shadow_q;
      sample_d       = sample_q;
      sample_valid_d = 1'b0;
      spi_start_d    = 1'b0;
      spi_data_in_d  = spi_data_in_q;
      ready_d        = ready_q;
      cs_n_d         = (state_d == ST_GAP) || (state_d == ST_IDLE);
      case (state_q)
         ST_WAKE_SETUP, ST_BURST_SETUP: begin
            if (gap_done) begin
               gap_cnt_d  = 8'd0;
               byte_idx_d = 4'd0;
            end else begin
               gap_cnt_d  = gap_cnt_q + 8'd1;
            end
         end
         ST_ISSUE: begin
            if (issue_ok) begin
               spi_start_d   = 1'b1;
               spi_data_in_d = tx_byte;
            end else begin
               spi_start_d   = 1'b0;
            end
         end
         ST_WAIT: begin
            if (spi_new_data) begin
               // The reply to the address byte carries no data and is skipped.
               if (is_burst_q && (byte_idx_q != 4'd0)) begin
                  shadow_d = {shadow_q[SAMPLE_W-9:0], spi_data_out};
               end else begin
                  shadow_d = shadow_q;
               end
               byte_idx_d = byte_idx_q + 4'd1;
            end else begin
               byte_idx_d = byte_idx_q;
            end
         end
         ST_HOLD: gap_cnt_d = 8'd0;
         ST_GAP: begin
            if (gap_done) begin
               gap_cnt_d = 8'd0;
               if (is_burst_q) begin
                  sample_d       = shadow_q << ALIGN_BITS;
                  sample_valid_d = 1'b1;
               end else begin
                  ready_d        = 1'b1;
               end
            end else begin
               gap_cnt_d = gap_cnt_q + 8'd1;
            end
         end
         ST_IDLE: begin
            if (burst_go) begin
               is_burst_d = 1'b1;
               shadow_d   = '0;
               gap_cnt_d  = 8'd0;
            end else begin
               is_burst_d = is_burst_q;
            end
         end
         default: gap_cnt_d = 8'd0;
      endcase
   end

endmodule

// File: tb/tb_mpu_burst_reader.sv
// Directed bench for mpu_burst_reader with a behavioural SPI master + MPU slave.
module tb_mpu_burst_reader;

   localparam int BT = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         trigger = 1'b0;
   logic         spi_busy = 1'b0;
   logic         spi_new_data = 1'b0;
   logic [7:0]   spi_data_out = 8'h00;
   logic         spi_start;
   logic [7:0]   spi_data_in;
   logic         cs_n;
   logic         ready;
   logic [111:0] sample;
   logic         sample_valid;
   logic         overrun;

   int n_checks = 0;
   int n_pass = 0;

   logic [7:0]   rom [14];
   logic [7:0]   mosi_log [$];
   int           proto_err = 0;
   int           valid_cnt = 0;
   int           overrun_cnt = 0;
   int           cyc = 0;
   int           valid_cyc [$];
   int           fall_cyc [$];
   logic         cs_n_prev = 1'b1;
   int           m_busy_cnt = 0;
   int           m_sl_idx = 0;
   logic [7:0]   m_resp = 8'h00;
   logic [111:0] exp1;

   always #5 clk = ~clk;

   mpu_burst_reader dut (
      .clk          (clk),
      .rst          (rst),
      .trigger      (trigger),
      .spi_busy     (spi_busy),
      .spi_new_data (spi_new_data),
      .spi_data_out (spi_data_out),
      .spi_start    (spi_start),
      .spi_data_in  (spi_data_in),
      .cs_n         (cs_n),
      .ready        (ready),
      .sample       (sample),
      .sample_valid (sample_valid),
      .overrun      (overrun)
   );

   // SPI master + slave model: BT busy cycles per byte, then a new_data pulse.
   initial begin
      forever begin
         @(posedge clk); #1;
         if (rst) begin
            m_busy_cnt   = 0;
            m_sl_idx     = 0;
            spi_busy     = 1'b0;
            spi_new_data = 1'b0;
         end else begin
            if (spi_start && (spi_busy || spi_new_data || cs_n)) proto_err++;
            spi_new_data = 1'b0;
            if (cs_n) m_sl_idx = 0;
            if (m_busy_cnt > 0) begin
               m_busy_cnt--;
               if (m_busy_cnt == 0) begin
                  spi_busy     = 1'b0;
                  spi_new_data = 1'b1;
                  spi_data_out = m_resp;
               end
            end else if (spi_start) begin
               mosi_log.push_back(spi_data_in);
               if (m_sl_idx == 0)       m_resp = 8'hA5;
               else if (m_sl_idx <= 14) m_resp = rom[m_sl_idx-1];
               else                     m_resp = 8'h00;
               m_sl_idx++;
               spi_busy   = 1'b1;
               m_busy_cnt = BT;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (sample_valid === 1'b1) begin
            valid_cnt++;
            valid_cyc.push_back(cyc);
         end
         if (overrun === 1'b1) overrun_cnt++;
         if (cs_n_prev === 1'b1 && cs_n === 1'b0) fall_cyc.push_back(cyc);
         cs_n_prev = cs_n;
      end
   end

   task automatic pulse_trigger;
      @(negedge clk); trigger = 1'b1;
      @(negedge clk); trigger = 1'b0;
   endtask

   task automatic wait_valid(input int target, input int budget);
      int k = 0;
      while (valid_cnt < target && k < budget) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (valid_cnt < target) $display("FAIL valid_timeout: got %0d pulses, need %0d", valid_cnt, target);
      else n_pass++;
   endtask

   task automatic wait_ready(input int budget);
      int k = 0;
      while (ready !== 1'b1 && k < budget) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (ready !== 1'b1) $display("FAIL ready_timeout: ready=%b after %0d cycles", ready, k);
      else n_pass++;
   endtask

   task automatic check_wake_bytes(input string name);
      n_checks++;
      if (mosi_log.size() != 2 || mosi_log[0] !== 8'h6B || mosi_log[1] !== 8'h00)
         $display("FAIL %s: %0d bytes, first %h, need 2 bytes 6b 00", name, mosi_log.size(),
                  (mosi_log.size() > 0) ? mosi_log[0] : 8'hxx);
      else n_pass++;
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({cs_n, spi_start, ready, sample_valid, overrun} !== 5'b10000)
         $display("FAIL reset_ctrl: {cs_n,start,ready,valid,ovr}=%b need 10000",
                  {cs_n, spi_start, ready, sample_valid, overrun});
      else n_pass++;
      n_checks++;
      if (spi_data_in !== 8'h00) $display("FAIL reset_data_in: got %h need 00", spi_data_in);
      else n_pass++;
      n_checks++;
      if (sample !== 112'h0) $display("FAIL reset_sample: got %h need 0", sample);
      else n_pass++;
   endtask

   task automatic test_wake_early_trigger;
      int base_v, base_o;
      mosi_log.delete();
      base_v = valid_cnt;
      base_o = overrun_cnt;
      @(negedge clk); rst = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (cs_n !== 1'b0) $display("FAIL wake_cs_low: cs_n=%b need 0", cs_n);
      else n_pass++;
      pulse_trigger();
      wait_ready(2000);
      check_wake_bytes("wake_mosi");
      repeat (200) @(negedge clk);
      n_checks++;
      if (mosi_log.size() != 2) $display("FAIL early_trigger_burst: %0d bytes sent, need 2", mosi_log.size());
      else n_pass++;
      n_checks++;
      if ((valid_cnt - base_v) != 0 || (overrun_cnt - base_o) != 0)
         $display("FAIL early_trigger_flags: valid=%0d overrun=%0d need 0 0", valid_cnt - base_v, overrun_cnt - base_o);
      else n_pass++;
      n_checks++;
      if (cs_n !== 1'b1) $display("FAIL idle_cs_high: cs_n=%b need 1", cs_n);
      else n_pass++;
   endtask

   task automatic test_burst;
      int base_v, nz;
      mosi_log.delete();
      base_v = valid_cnt;
      pulse_trigger();
      n_checks++;
      if (cs_n !== 1'b0) $display("FAIL burst_immediate_start: cs_n=%b need 0", cs_n);
      else n_pass++;
      wait_valid(base_v + 1, 3000);
      repeat (20) @(negedge clk);
      n_checks++;
      if (sample !== exp1) $display("FAIL burst_sample: got %h need %h", sample, exp1);
      else n_pass++;
      n_checks++;
      if ((valid_cnt - base_v) != 1) $display("FAIL burst_valid_count: got %0d need 1", valid_cnt - base_v);
      else n_pass++;
      n_checks++;
      if (mosi_log.size() != 15 || mosi_log[0] !== 8'hBB)
         $display("FAIL burst_cmd: %0d bytes first %h, need 15 bytes first bb", mosi_log.size(),
                  (mosi_log.size() > 0) ? mosi_log[0] : 8'hxx);
      else n_pass++;
      nz = 0;
      for (int i = 1; i < mosi_log.size(); i++) if (mosi_log[i] !== 8'h00) nz++;
      n_checks++;
      if (nz != 0) $display("FAIL burst_dummy: %0d nonzero dummy bytes, need 0", nz);
      else n_pass++;
   endtask

   task automatic test_negative;
      int base_v;
      base_v = valid_cnt;
      rom[0] = 8'hFF;
      rom[1] = 8'h38;
      pulse_trigger();
      repeat (60) @(negedge clk);
      n_checks++;
      if (sample !== exp1) $display("FAIL no_mid_burst_update: got %h need %h", sample, exp1);
      else n_pass++;
      wait_valid(base_v + 1, 3000);
      n_checks++;
      if (sample[111:96] !== 16'hFF38) $display("FAIL neg_ax_raw: got %h need ff38", sample[111:96]);
      else n_pass++;
      n_checks++;
      if (int'($signed(sample[111:96])) != -200)
         $display("FAIL neg_ax_value: got %0d need -200", int'($signed(sample[111:96])));
      else n_pass++;
      n_checks++;
      if (sample[95:0] !== exp1[95:0]) $display("FAIL neg_other_words: got %h need %h", sample[95:0], exp1[95:0]);
      else n_pass++;
      rom[0] = 8'h01;
      rom[1] = 8'h02;
      repeat (20) @(negedge clk);
   endtask

   task automatic test_back_to_back;
      int base_v, base_o, nv0, v1, found;
      mosi_log.delete();
      base_v = valid_cnt;
      base_o = overrun_cnt;
      nv0    = valid_cyc.size();
      pulse_trigger();
      repeat (30) @(negedge clk);
      pulse_trigger();
      repeat (10) @(negedge clk);
      pulse_trigger();
      repeat (3) @(negedge clk);
      n_checks++;
      if ((overrun_cnt - base_o) != 1) $display("FAIL overrun_pulse: got %0d cycles need 1", overrun_cnt - base_o);
      else n_pass++;
      wait_valid(base_v + 2, 5000);
      repeat (300) @(negedge clk);
      n_checks++;
      if ((valid_cnt - base_v) != 2) $display("FAIL b2b_valid_count: got %0d need 2", valid_cnt - base_v);
      else n_pass++;
      n_checks++;
      if (mosi_log.size() != 30 || mosi_log[15] !== 8'hBB)
         $display("FAIL b2b_bytes: got %0d bytes need 30 with second cmd bb", mosi_log.size());
      else n_pass++;
      found = 0;
      v1 = (valid_cyc.size() > nv0) ? valid_cyc[nv0] : -10;
      foreach (fall_cyc[i]) if (fall_cyc[i] == v1 + 1) found = 1;
      n_checks++;
      if (found != 1) $display("FAIL pending_start: no cs_n fall 1 cycle after valid at cyc %0d", v1);
      else n_pass++;
      n_checks++;
      if (sample !== exp1) $display("FAIL b2b_sample: got %h need %h", sample, exp1);
      else n_pass++;
      n_checks++;
      if ((overrun_cnt - base_o) != 1) $display("FAIL overrun_total: got %0d need 1", overrun_cnt - base_o);
      else n_pass++;
   endtask

   task automatic test_reset_mid_burst;
      int base_v, k;
      mosi_log.delete();
      base_v = valid_cnt;
      pulse_trigger();
      k = 0;
      while (mosi_log.size() < 5 && k < 1000) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (mosi_log.size() < 5) $display("FAIL byte5_timeout: got %0d bytes need 5", mosi_log.size());
      else n_pass++;
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (cs_n !== 1'b1 || sample !== 112'h0)
         $display("FAIL async_reset: cs_n=%b sample=%h need 1 and 0", cs_n, sample);
      else n_pass++;
      n_checks++;
      if (ready !== 1'b0 || spi_start !== 1'b0)
         $display("FAIL async_reset_ctrl: ready=%b start=%b need 0 0", ready, spi_start);
      else n_pass++;
      repeat (2) @(negedge clk);
      mosi_log.delete();
      rst = 1'b0;
      wait_ready(2000);
      check_wake_bytes("rewake_mosi");
      repeat (300) @(negedge clk);
      n_checks++;
      if (valid_cnt != base_v || mosi_log.size() != 2)
         $display("FAIL aborted_burst: valid=%0d bytes=%0d need 0 and 2", valid_cnt - base_v, mosi_log.size());
      else n_pass++;
   endtask

   task automatic test_protocol;
      n_checks++;
      if (proto_err != 0) $display("FAIL spi_start_protocol: got %0d violations need 0", proto_err);
      else n_pass++;
   endtask

   initial begin
      for (int i = 0; i < 14; i++) rom[i] = 8'(i + 1);
      exp1 = 112'h0102_0304_0506_0708_090A_0B0C_0D0E;
      test_reset();
      test_wake_early_trigger();
      test_burst();
      test_negative();
      test_back_to_back();
      test_reset_mid_burst();
      test_protocol();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
